// File: rtl/alu_proc_pkg.sv
// alu_proc_pkg: shared widths, op codes, instruction fields and FSM states for the 8-bit ALU processor
package alu_proc_pkg;
  localparam int NREGS = 4;
  localparam int DW = 8;
  localparam int AW = $clog2(NREGS);
  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int RD_MSB = 5;
  localparam int RD_LSB = 4;
  localparam int RS1_MSB = 3;
  localparam int RS1_LSB = 2;
  localparam int RS2_MSB = 1;
  localparam int RS2_LSB = 0;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;
endpackage

// File: rtl/alu_regfile_ctrl_if.sv
// alu_regfile_ctrl_if: instruction, load, ALU and debug signals of the register-file front end
interface alu_regfile_ctrl_if;
  import alu_proc_pkg::*;
  logic instr_valid;
  logic [DW-1:0] instr;
  logic instr_ready;
  logic ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [1:0] alu_op;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [DW-1:0] alu_out;
  logic alu_write_reg;
  logic done;
  logic busy;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  modport master (
    output instr_valid, instr, ld_en, ld_addr, ld_data, alu_out, alu_write_reg, dbg_addr,
    input instr_ready, alu_op, alu_in1, alu_in2, done, busy, dbg_data
  );
  modport slave (
    input instr_valid, instr, ld_en, ld_addr, ld_data, alu_out, alu_write_reg, dbg_addr,
    output instr_ready, alu_op, alu_in1, alu_in2, done, busy, dbg_data
  );
endinterface

// File: rtl/reg_bank_4x8.sv
// reg_bank_4x8: four 8-bit registers, one synchronous write port, three combinational read ports
module reg_bank_4x8 import alu_proc_pkg::*; (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [AW-1:0] ra3,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic [DW-1:0] rd3
);
  logic [DW-1:0] regs [NREGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs <= '{default: '0};
    else if (we) regs[waddr] <= wdata;
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
  assign rd3 = regs[ra3];
endmodule

// File: rtl/alu_regfile_ctrl.sv
// alu_regfile_ctrl: accepts packed instructions, feeds the ALU from the register file and writes results back
module alu_regfile_ctrl import alu_proc_pkg::*; (
  input logic clk,
  input logic rst_n,
  alu_regfile_ctrl_if.slave bus
);
  state_t state, state_n;
  logic accept, we, wen_q, done_q;
  logic [AW-1:0] rd_q, waddr;
  logic [DW-1:0] wdata, res_q, in1_q, in2_q, rs1_data, rs2_data;
  logic [1:0] op_q;
  assign bus.instr_ready = state == IDLE && !bus.ld_en;
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  assign bus.alu_op = op_q;
  assign bus.alu_in1 = in1_q;
  assign bus.alu_in2 = in2_q;
  assign accept = bus.instr_valid && bus.instr_ready;
  // the single write port is shared: loads only in IDLE, writeback only in WB
  always_comb begin
    state_n = state == IDLE ? (accept ? EXEC : IDLE) : state == EXEC ? WB : IDLE;
    we = (state == IDLE && bus.ld_en) || (state == WB && wen_q);
    waddr = state == WB ? rd_q : bus.ld_addr;
    wdata = state == WB ? res_q : bus.ld_data;
  end
  reg_bank_4x8 u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .ra1   (bus.instr[RS1_MSB:RS1_LSB]),
    .ra2   (bus.instr[RS2_MSB:RS2_LSB]),
    .ra3   (bus.dbg_addr),
    .rd1   (rs1_data),
    .rd2   (rs2_data),
    .rd3   (bus.dbg_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      rd_q <= '0;
      res_q <= '0;
      wen_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= state == WB;
      if (accept) begin
        op_q <= bus.instr[OP_MSB:OP_LSB];
        in1_q <= rs1_data;
        in2_q <= rs2_data;
        rd_q <= bus.instr[RD_MSB:RD_LSB];
      end
      if (state == EXEC) begin
        res_q <= bus.alu_out;
        wen_q <= bus.alu_write_reg;
      end
    end
endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// tb_alu_regfile_ctrl: directed vectors checked every cycle against a transaction-level register-file model
module tb_alu_regfile_ctrl;
  import alu_proc_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_regfile_ctrl_if bus();
  alu_regfile_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    return op == OP_AND ? (a & b) : op == OP_OR ? (a | b) : op == OP_XOR ? (a ^ b) : ~a;
  endfunction
  assign bus.alu_out = alu_f(bus.alu_op, bus.alu_in1, bus.alu_in2);
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  logic [7:0] m_regs [4];
  bit pend, m_wen, m_done;
  int cyc, due;
  logic [1:0] m_rd, m_op;
  logic [7:0] m_val, m_in1, m_in2;
  // an accepted instruction retires two edges later with the value its operands had at accept
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_regs = '{default: 8'h00};
      pend = 0; m_wen = 0; m_done = 0; cyc = 0; due = 0;
      m_rd = 0; m_op = 0; m_val = 0; m_in1 = 0; m_in2 = 0;
    end else begin
      cyc++;
      m_done = 0;
      if (pend && cyc == due) begin
        if (m_wen) m_regs[m_rd] = m_val;
        m_done = 1;
        pend = 0;
      end else if (pend) m_wen = bus.alu_write_reg;
      else if (bus.ld_en) m_regs[bus.ld_addr] = bus.ld_data;
      else if (bus.instr_valid) begin
        m_op = bus.instr[7:6];
        m_rd = bus.instr[5:4];
        m_in1 = m_regs[bus.instr[3:2]];
        m_in2 = m_regs[bus.instr[1:0]];
        m_val = alu_f(m_op, m_in1, m_in2);
        pend = 1;
        due = cyc + 2;
      end
    end
  end
  logic [1:0] dptr = 2'd0;
  always @(negedge clk) if (rst_n) begin
    bus.dbg_addr = dptr;
    #1;
    chk("instr_ready", 8'(bus.instr_ready), 8'(!pend && !bus.ld_en));
    chk("busy", 8'(bus.busy), 8'(pend));
    chk("done", 8'(bus.done), 8'(m_done));
    chk("alu_op", 8'(bus.alu_op), 8'(m_op));
    chk("alu_in1", bus.alu_in1, m_in1);
    chk("alu_in2", bus.alu_in2, m_in2);
    chk("dbg_data", bus.dbg_data, m_regs[dptr]);
    dptr++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [1:0] a, input logic [7:0] d);
    bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    tick;
    bus.ld_en = 1'b0;
  endtask
  task automatic issue(input logic [7:0] i, input logic wen, input logic exec_ld);
    bit ok = 0;
    bus.instr_valid = 1'b1;
    bus.instr = i;
    for (int k = 0; k < 8 && !ok; k++) begin
      ok = bus.instr_ready;
      tick;
    end
    bus.instr_valid = 1'b0;
    chk("accept", 8'(ok), 8'd1);
    if (!ok) return;
    bus.alu_write_reg = wen;
    if (exec_ld) begin
      bus.ld_en = 1'b1; bus.ld_addr = 2'd0; bus.ld_data = 8'hFF;
    end
    tick;
    bus.ld_en = 1'b0;
    bus.alu_write_reg = 1'b1;
    tick;
    chk("done_at_accept_plus_2", 8'(bus.done), 8'd1);
  endtask
  initial begin
    bus.instr_valid = 0; bus.instr = 0; bus.ld_en = 0; bus.ld_addr = 0; bus.ld_data = 0;
    bus.alu_write_reg = 1; bus.dbg_addr = 0;
    #12 rst_n = 1'b1;
    tick;
    chk("reset_ready", 8'(bus.instr_ready), 8'd1);
    chk("reset_busy", 8'(bus.busy), 8'd0);
    chk("reset_done", 8'(bus.done), 8'd0);
    chk("reset_in1", bus.alu_in1, 8'h00);
    load(2'd1, 8'h0F); load(2'd2, 8'h3C);
    issue(8'h36, 1, 0);
    chk("and_r3", m_regs[3], 8'h0C);
    issue(8'h46, 1, 0);
    chk("or_r0", m_regs[0], 8'h3F);
    issue(8'h86, 1, 0);
    chk("xor_r0", m_regs[0], 8'h33);
    issue(8'hE4, 1, 0);
    chk("not_r2", m_regs[2], 8'hF0);
    load(2'd1, 8'h0F); load(2'd2, 8'h3C); load(2'd0, 8'h00);
    issue(8'h86, 1, 0);
    issue(8'h12, 1, 0);
    chk("b2b_r0", m_regs[0], 8'h33);
    chk("b2b_r1", m_regs[1], 8'h30);
    bus.instr_valid = 1'b1; bus.instr = 8'h3A;
    bus.ld_en = 1'b1; bus.ld_addr = 2'd2; bus.ld_data = 8'hAA;
    #1 chk("ld_blocks_ready", 8'(bus.instr_ready), 8'd0);
    tick;
    bus.ld_en = 1'b0;
    issue(8'h3A, 1, 0);
    chk("ld_then_and_r3", m_regs[3], 8'hAA);
    issue(8'h06, 0, 1);
    chk("nowen_r0", m_regs[0], 8'h33);
    chk("nowen_r2", m_regs[2], 8'hAA);
    bus.instr_valid = 1'b1; bus.instr = 8'hE4;
    tick;
    bus.instr_valid = 1'b0;
    chk("rst_accepted_busy", 8'(bus.busy), 8'd1);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    tick;
    for (int r = 0; r < 4; r++) chk("rst_reg_zero", m_regs[r], 8'h00);
    chk("rst_ready", 8'(bus.instr_ready), 8'd1);
    tick; tick; tick;
    chk("rst_no_done", 8'(bus.done), 8'd0);
    load(2'd3, 8'h5A);
    issue(8'hDC, 1, 0);
    chk("after_rst_not_r3", m_regs[1], 8'hA5);
    tick; tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_regfile_ctrl.md
# alu_regfile_ctrl

Register-file and sequencing front end for the 8-bit ALU processor. It accepts packed 8-bit instructions over a valid/ready handshake and reads two source registers from a 4×8 register file. It drives the ALU's `op`, `in1` and `in2` inputs, captures the ALU result qualified by `write_reg`, and writes it back to the destination register. A side load port initialises registers, and a debug read port exposes register contents.

## Interface
- `NREGS`, 4, register count (address width = 2).
- `DW`, 8, data width.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `instr_valid`  in  1  instruction offered.
- `instr`  in  8  instruction: [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2.
- `instr_ready`  out  1  block can accept an instruction this cycle.
- `ld_en`  in  1  register load strobe.
- `ld_addr`  in  2  load target register.
- `ld_data`  in  8  load value.
- `alu_op`  out  2  registered op to ALU.
- `alu_in1`  out  8  registered operand 1 to ALU.
- `alu_in2`  out  8  registered operand 2 to ALU.
- `alu_out`  in  8  ALU result (combinational from `alu_*`).
- `alu_write_reg`  in  1  ALU write-enable qualifier.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `busy`  out  1  high in EXEC or WB.
- `dbg_addr`  in  2  debug read address.
- `dbg_data`  out  8  combinational `regs[dbg_addr]`.

## Operation
- Op encoding (ALU-defined): 00 AND, 01 OR, 10 XOR, 11 NOT in1 (rs2 ignored by ALU).
- FSM states: IDLE, EXEC, WB.
  - IDLE → EXEC on accept: `instr_valid && instr_ready`.
    - At the accept edge: `alu_op` ← op, `alu_in1` ← regs[rs1], `alu_in2` ← regs[rs2], rd latched.
  - EXEC → WB unconditionally.
    - At that edge: `res_q` ← `alu_out`, `wen_q` ← `alu_write_reg`.
  - WB → IDLE unconditionally.
    - At that edge: if `wen_q`, regs[rd] ← `res_q`; `done` ← 1 for one cycle.
    - If `wen_q` = 0, no register changes, but `done` still pulses.
- `instr_ready` = (state == IDLE) && !`ld_en`. Load has priority; an instruction is never accepted in a cycle with `ld_en` high.
- Load: when state == IDLE and `ld_en` = 1, regs[ld_addr] ← `ld_data` at the edge. `ld_en` is ignored in EXEC and WB (no write, no stall, no error).
- Operands are read at the accept edge and see all prior WB and load writes. No forwarding is needed because accepts occur only in IDLE.
- rd may equal rs1 or rs2; the write happens in WB after the operands were captured.
- `alu_op`/`alu_in1`/`alu_in2` hold their values after WB until the next accept.
- No arithmetic widening: all data paths are exactly 8 bits.

## Timing
- Reset (async assert, synchronous release by `clk`): state IDLE, all regs 0x00, `alu_op` 00, `alu_in1`/`alu_in2` 0x00, `res_q` 0, `wen_q` 0, `done` 0, `busy` 0.
  - `instr_ready` is 1 after reset when `ld_en` is low.
  - `dbg_data` = 0x00.
- Latency: accept at edge N, result written and `done` high after edge N+2, new value visible on `dbg_data` after edge N+2.
- Throughput: one instruction per 3 cycles. `instr_ready` is low in the two cycles following an accept.
- Reset asserted mid-instruction: the in-flight instruction is discarded, no writeback, no `done`.
- `done` and `instr_ready` can both be high in the cycle after WB. A new accept in that cycle is legal.

## Structure
- Shared package `alu_proc_pkg`:
  - op constants `OP_AND`/`OP_OR`/`OP_XOR`/`OP_NOT`;
  - instruction field bit positions;
  - FSM state encoding (IDLE = 0, EXEC = 1, WB = 2).
- One sub-module: `reg_bank_4x8`.
  - 4×8 flops, async reset to zero.
  - One synchronous write port (muxed load/WB).
  - Three combinational read ports (rs1, rs2, dbg).
- The FSM and pipeline registers live in the top.

## Test plan
- Load r1 = 0x0F, r2 = 0x3C. Then instr 0x36 (AND, rd3, rs1, rs2) → `done` after accept+2, r3 = 0x0C.
- Same loads. OR into r0 (0x46) → r0 = 0x3F. XOR into r0 (0x86) → r0 = 0x33. NOT r1 into r2 (0xE4) → r2 = 0xF0.
- Back-to-back dependency: r1 = 0x0F, r2 = 0x3C, XOR r0 ← r1^r2, then AND r1 ← r0&r2 offered in the same cycle as `done` → r0 = 0x33, r1 = 0x30.
- Hold `instr_valid` and `ld_en` (r2 ← 0xAA) together for one IDLE cycle → `instr_ready` 0, r2 = 0xAA. The instruction is accepted next cycle using 0xAA.
- Hold `alu_write_reg` low during EXEC → `done` pulses, regs unchanged. Assert `ld_en` during EXEC → ignored.
- Assert `rst_n` low during EXEC → all regs 0x00, no `done`, IDLE and `instr_ready` = 1 after release.
